// File: rtl/obc_pkg.sv
// ----------------------------------------------------------------------------
// obc_pkg
// Shared definitions for the offset-binary-coded distributed-arithmetic
// sequencer: number of ROM-bank inputs, default widths, FSM state type and
// the sample bit-extraction helper used by the slice shifter.
// ----------------------------------------------------------------------------
package obc_pkg;

    localparam int N_IN       = 16;
    localparam int OBC_DATA_W = 16;
    localparam int OBC_ACC_W  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } obc_state_t;

    // Return bit idx of a sample; samples are zero-extended to 64 bits by
    // the caller so one helper serves every DATA_W up to 64.
    function automatic logic sample_bit(input logic [63:0] s,
                                        input logic [5:0]  idx);
        return s[idx];
    endfunction

endpackage

// File: rtl/obc_slice_shifter.sv
// ----------------------------------------------------------------------------
// obc_slice_shifter
// Holds the N_IN sample registers and presents one bit-slice per cycle,
// MSB first.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : capture din and present the MSB slice
//   advance   : present the next lower bit slice
//   clear     : drive the slice to zero (frame finished)
//   din       : N_IN packed samples, sample k at [k*DATA_W +: DATA_W]
//   x_slice   : bit k = current bit of sample k
// ----------------------------------------------------------------------------
module obc_slice_shifter
    import obc_pkg::*;
#(
    parameter int DATA_W = OBC_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic                     advance,
    input  logic                     clear,
    input  logic [N_IN*DATA_W-1:0]   din,
    output logic [N_IN-1:0]          x_slice
);

    localparam logic [5:0] MSB_IDX = 6'(DATA_W - 1);

    // Samples are kept pre-shifted so that their MSB is always the bit to
    // present on the next advance.
    logic [DATA_W-1:0] smp_p0 [N_IN];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_IN; k++) smp_p0[k] <= '0;
            x_slice <= '0;
        end else if (load) begin
            for (int k = 0; k < N_IN; k++) begin
                x_slice[k] <= sample_bit(64'(din[k*DATA_W +: DATA_W]), MSB_IDX);
                smp_p0[k]  <= din[k*DATA_W +: DATA_W] << 1;
            end
        end else if (advance) begin
            for (int k = 0; k < N_IN; k++) begin
                x_slice[k] <= sample_bit(64'(smp_p0[k]), MSB_IDX);
                smp_p0[k]  <= smp_p0[k] << 1;
            end
        end else if (clear) begin
            x_slice <= '0;
        end
    end

endmodule

// File: rtl/obc_da_sequencer.sv
// ----------------------------------------------------------------------------
// obc_da_sequencer
// Bit-serial controller for one 16-input OBC distributed-arithmetic ROM bank.
// Accepts a frame of 16 signed samples, feeds the bank one bit-slice per cycle
// (MSB first, m=1 on the sign slice), shift-accumulates the bank output, adds
// the OBC offset and returns one DFT term over a valid/ready handshake.
//
// Build option: define OBC_DA_SAT_EN to saturate the final offset add to the
// signed ACC_W range; otherwise the final add wraps.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : frame handshake, din holds 16 samples
//   x_slice, m          : bit-slice and sign select to the ROM bank
//   romout              : combinational partial sum from the ROM bank
//   out_valid/out_ready : result handshake, result is the signed DFT term
//   busy                : high while shifting or holding a result
// ----------------------------------------------------------------------------
module obc_da_sequencer
    import obc_pkg::*;
#(
    parameter int                       DATA_W = OBC_DATA_W,
    parameter int                       ACC_W  = OBC_ACC_W,
    parameter logic signed [ACC_W-1:0]  OFFSET = 32'sd0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [N_IN*DATA_W-1:0]      din,
    output logic [N_IN-1:0]             x_slice,
    output logic                        m,
    input  logic signed [ACC_W-1:0]     romout,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [ACC_W-1:0]     result,
    output logic                        busy
);

    localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    obc_state_t                 state;
    logic [CNT_W-1:0]           cnt;
    logic signed [ACC_W-1:0]    acc_p0;
    logic signed [ACC_W-1:0]    acc_next;
    logic                       last_slice;
    logic                       sh_load;
    logic                       sh_advance;
    logic                       sh_clear;

    function automatic logic signed [ACC_W-1:0] add_offset(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
`ifdef OBC_DA_SAT_EN
        logic [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        // Sign bits disagree only on overflow; clamp toward the true sign.
        if (s[ACC_W] != s[ACC_W-1])
            return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        return s[ACC_W-1:0];
`else
        return a + b;
`endif
    endfunction

    // Shift-accumulate always wraps modulo 2^ACC_W.
    assign acc_next   = (acc_p0 <<< 1) + romout;
    assign last_slice = (cnt == CNT_LAST);

    assign sh_load    = (state == IDLE)  && in_valid && in_ready;
    assign sh_advance = (state == SHIFT) && !last_slice;
    assign sh_clear   = (state == SHIFT) && last_slice;

    obc_slice_shifter #(
        .DATA_W (DATA_W)
    ) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .load    (sh_load),
        .advance (sh_advance),
        .clear   (sh_clear),
        .din     (din),
        .x_slice (x_slice)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            m         <= 1'b0;
            result    <= '0;
            acc_p0    <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        m        <= 1'b1;
                        acc_p0   <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_p0 <= acc_next;
                    m      <= 1'b0;
                    if (last_slice) begin
                        result    <= add_offset(acc_next, OFFSET);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    // IDLE is entered with in_ready set, so a new frame can
                    // only be taken on the edge after the handshake.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
